// File: rtl/cuenta_unos_param.sv
// Serial ones/zeros counter with start/ocupado/fin handshake.
// Shifts one operand bit per clock and stops early once no set bits remain.
module cuenta_unos_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valor,
  input  logic                         start,
  input  logic                         modo,
  output logic [$clog2(WIDTH+1)-1:0]   cuenta,
  output logic                         fin,
  output logic                         ocupado
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [IW-1:0]    idx, idx_d;
  logic [CW-1:0]    cuenta_d;
  logic             fin_d, ocupado_d;
  logic             last;

  // Last bit of this operation: nothing set above bit 0, or all bits consumed.
  assign last = (sreg[WIDTH-1:1] == '0) || (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start) state_d = COUNT;
      COUNT:      if (last)  state_d = DONE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    sreg_d    = sreg;
    idx_d     = idx;
    cuenta_d  = cuenta;
    fin_d     = fin;
    ocupado_d = ocupado;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sreg_d    = modo ? ~valor : valor;
          idx_d     = '0;
          cuenta_d  = '0;
          fin_d     = 1'b0;
          ocupado_d = 1'b1;
        end
      end
      COUNT: begin
        cuenta_d = cuenta + CW'(sreg[0]);
        sreg_d   = sreg >> 1;
        idx_d    = idx + IW'(1);
        if (last) begin
          fin_d     = 1'b1;
          ocupado_d = 1'b0;
        end
      end
      default: begin
        fin_d     = 1'b0;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      idx     <= '0;
      cuenta  <= '0;
      fin     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      sreg    <= sreg_d;
      idx     <= idx_d;
      cuenta  <= cuenta_d;
      fin     <= fin_d;
      ocupado <= ocupado_d;
    end
  end

endmodule
